// File: rtl/block_scroller.sv
// Scrolling obstacle controller: moves the block left once per frame, latches the
// pitch that sets its gap, tests the player against it and keeps score.
module block_scroller #(
  parameter int unsigned SCREEN_WIDTH = 1280,
  parameter int unsigned BLOCK_WIDTH  = 32,
  parameter int unsigned GAP_HEIGHT   = 50,
  parameter int unsigned Y_HEIGHT     = 208,
  parameter int unsigned SPEED        = 4,
  parameter int unsigned PLAYER_X     = 200,
  parameter int unsigned PLAYER_SIZE  = 16,
  parameter int unsigned FRAME_LINE   = 720
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [15:0] freq_in,
  input  logic        freq_valid_in,
  input  logic [8:0]  gap_height_in,
  input  logic [9:0]  player_y_in,
  input  logic        start_in,
  output logic [12:0] x_out,
  output logic [15:0] freq_out,
  output logic [7:0]  score_out,
  output logic [1:0]  state_out,
  output logic        collision_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_t;

  localparam logic [12:0] SCREEN_W13  = 13'(SCREEN_WIDTH);
  localparam logic [12:0] SPEED13     = 13'(SPEED);
  localparam logic [13:0] SPEED14     = 14'(SPEED);
  localparam logic [13:0] BLOCK_W14   = 14'(BLOCK_WIDTH);
  localparam logic [13:0] GAP_H14     = 14'(GAP_HEIGHT);
  localparam logic [13:0] Y_H14       = 14'(Y_HEIGHT);
  localparam logic [13:0] PLAYER_X14  = 14'(PLAYER_X);
  localparam logic [13:0] PLAYER_S14  = 14'(PLAYER_SIZE);
  localparam logic [9:0]  FRAME_LN10  = 10'(FRAME_LINE);

  state_t      state_q, state_d;
  logic [12:0] x_q, x_d;
  logic [15:0] freq_q, freq_d;
  logic [15:0] pend_q, pend_d;
  logic [7:0]  score_q, score_d;
  logic        coll_q, coll_d;
  logic        match_q, match_d;

  logic        tick;
  logic [13:0] x_ext, py_ext, gap_ext;
  logic        hov, top, bot, hit;

  always_comb begin
    x_ext   = {1'b0, x_q};
    py_ext  = {4'b0, player_y_in};
    gap_ext = {5'b0, gap_height_in};
    hov = (x_ext + BLOCK_W14 > PLAYER_X14) && (x_ext < PLAYER_X14 + PLAYER_S14);
    top = (py_ext < gap_ext) && (py_ext + PLAYER_S14 > Y_H14);
    bot = (py_ext + PLAYER_S14) > (gap_ext + GAP_H14);
    hit = hov && (top || bot);
  end

  // The tick fires on the first cycle of a counter match so a stalled scan
  // position cannot advance the block more than once.
  always_comb begin
    match_d = (hcount_in == 11'd0) && (vcount_in == FRAME_LN10);
    tick    = match_d && !match_q;

    state_d = state_q;
    x_d     = x_q;
    freq_d  = freq_q;
    pend_d  = freq_valid_in ? freq_in : pend_q;
    score_d = score_q;
    coll_d  = 1'b0;

    case (state_q)
      IDLE: begin
        x_d = SCREEN_W13;
        if (start_in) begin
          state_d = RUN;
          score_d = 8'd0;
          freq_d  = pend_q;
        end
      end
      RUN: begin
        if (tick) begin
          if (hit) begin
            state_d = HIT;
            coll_d  = 1'b1;
          end else if (x_ext < SPEED14) begin
            x_d    = SCREEN_W13;
            freq_d = pend_q;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
          end else begin
            x_d = x_q - SPEED13;
          end
        end
      end
      HIT: begin
        if (start_in) begin
          state_d = IDLE;
          x_d     = SCREEN_W13;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= SCREEN_W13;
      freq_q  <= 16'd0;
      pend_q  <= 16'd0;
      score_q <= 8'd0;
      coll_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      freq_q  <= freq_d;
      pend_q  <= pend_d;
      score_q <= score_d;
      coll_q  <= coll_d;
      match_q <= match_d;
    end
  end

  assign x_out         = x_q;
  assign freq_out      = freq_q;
  assign score_out     = score_q;
  assign state_out     = state_q;
  assign collision_out = coll_q;

endmodule

// File: tb/tb_block_scroller.sv
// Self-checking bench for block_scroller: vector table, hand-written corner
// sequences and randomized stimulus against a frame-level reference model.
module tb_block_scroller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcount_in = 11'd1;
  logic [9:0]  vcount_in = 10'd720;
  logic [15:0] freq_in = 16'd0;
  logic        freq_valid_in = 1'b0;
  logic [8:0]  gap_height_in = 9'd208;
  logic [9:0]  player_y_in = 10'd0;
  logic        start_in = 1'b0;

  logic [12:0] x_out, x_s;
  logic [15:0] freq_out, freq_s;
  logic [7:0]  score_out, score_s;
  logic [1:0]  state_out, state_s;
  logic        collision_out, coll_s;

  int tests_run = 0;
  int failures  = 0;
  bit seen_coll;

  int m_state, m_x, m_freq, m_pend, m_score, m_coll;
  bit m_prev;

  always #5 clk = ~clk;

  block_scroller dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .freq_in(freq_in), .freq_valid_in(freq_valid_in), .gap_height_in(gap_height_in),
    .player_y_in(player_y_in), .start_in(start_in), .x_out(x_out),
    .freq_out(freq_out), .score_out(score_out), .state_out(state_out),
    .collision_out(collision_out)
  );

  // Same block with a speed that empties the screen in one tick, to reach
  // the score ceiling quickly.
  block_scroller #(.SPEED(1280)) dut_s (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .freq_in(freq_in), .freq_valid_in(freq_valid_in), .gap_height_in(gap_height_in),
    .player_y_in(player_y_in), .start_in(start_in), .x_out(x_s),
    .freq_out(freq_s), .score_out(score_s), .state_out(state_s),
    .collision_out(coll_s)
  );

  typedef struct {
    bit          start;
    bit          valid;
    logic [15:0] fin;
    bit          tick;
    int          e_state;
    int          e_x;
    int          e_freq;
    int          e_score;
    int          e_coll;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_x = 1280; m_freq = 0; m_pend = 0; m_score = 0; m_coll = 0; m_prev = 0;
  endtask

  task automatic model_update();
    bit match, tick, hov, top, bot;
    int old_pend, py, gap;
    match = (hcount_in == 0) && (vcount_in == 720);
    tick = match && !m_prev;
    m_prev = match;
    old_pend = m_pend;
    if (freq_valid_in) m_pend = freq_in;
    m_coll = 0;
    py = player_y_in;
    gap = gap_height_in;
    case (m_state)
      0: begin
        m_x = 1280;
        if (start_in) begin m_state = 1; m_score = 0; m_freq = old_pend; end
      end
      1: if (tick) begin
        hov = (m_x + 32 > 200) && (m_x < 216);
        top = (py < gap) && (py + 16 > 208);
        bot = (py + 16) > (gap + 50);
        if (hov && (top || bot)) begin
          m_state = 2; m_coll = 1;
        end else if (m_x < 4) begin
          m_x = 1280; m_freq = old_pend;
          m_score = (m_score == 255) ? 255 : m_score + 1;
        end else begin
          m_x = m_x - 4;
        end
      end
      default: if (start_in) begin m_state = 0; m_x = 1280; end
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_reset(); else model_update();
    @(negedge clk);
    if (collision_out) seen_coll = 1;
  endtask

  task automatic apply_tick();
    hcount_in = 11'd0; vcount_in = 10'd720;
    cycle();
    hcount_in = 11'd1;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b0; start_in = 1'b0; freq_valid_in = 1'b0; hcount_in = 11'd1;
    cycle(); cycle();
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    cycle();
    start_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    model_reset();
    vecs[0] = '{0, 1, 16'h0100, 0, 0, 1280, 16'h0000, 0, 0};
    vecs[1] = '{1, 0, 16'h0000, 1, 1, 1280, 16'h0100, 0, 0};
    vecs[2] = '{0, 1, 16'h0222, 0, 1, 1280, 16'h0100, 0, 0};
    vecs[3] = '{0, 0, 16'h0000, 1, 1, 1276, 16'h0100, 0, 0};
    vecs[4] = '{0, 0, 16'h0000, 0, 1, 1276, 16'h0100, 0, 0};
    vecs[5] = '{1, 0, 16'h0000, 0, 1, 1276, 16'h0100, 0, 0};
    vecs[6] = '{1, 0, 16'h0000, 1, 1, 1272, 16'h0100, 0, 0};
    vecs[7] = '{0, 0, 16'h0000, 1, 1, 1272, 16'h0100, 0, 0};
    vecs[8] = '{0, 0, 16'h0000, 0, 1, 1272, 16'h0100, 0, 0};
    vecs[9] = '{0, 0, 16'h0000, 1, 1, 1268, 16'h0100, 0, 0};

    do_reset();
    check("reset_state", state_out, 0);
    check("reset_x", x_out, 1280);
    check("reset_freq", freq_out, 0);
    check("reset_score", score_out, 0);
    check("reset_coll", collision_out, 0);

    for (int i = 0; i < 10; i++) begin
      start_in = vecs[i].start;
      freq_valid_in = vecs[i].valid;
      freq_in = vecs[i].fin;
      hcount_in = vecs[i].tick ? 11'd0 : 11'd1;
      vcount_in = 10'd720;
      cycle();
      check($sformatf("vec%0d_state", i), state_out, vecs[i].e_state);
      check($sformatf("vec%0d_x", i), x_out, vecs[i].e_x);
      check($sformatf("vec%0d_freq", i), freq_out, vecs[i].e_freq);
      check($sformatf("vec%0d_score", i), score_out, vecs[i].e_score);
      check($sformatf("vec%0d_coll", i), collision_out, vecs[i].e_coll);
    end
    start_in = 0; freq_valid_in = 0; hcount_in = 11'd1;

    // Full traverse, wrap, then collision and restart.
    do_reset();
    player_y_in = 10'd208; gap_height_in = 9'd208;
    pulse_start();
    check("wrap_start_state", state_out, 1);
    seen_coll = 0;
    for (int i = 0; i < 319; i++) apply_tick();
    freq_valid_in = 1; freq_in = 16'h0ABC;
    cycle();
    freq_valid_in = 0;
    apply_tick();
    check("wrap_x_zero", x_out, 0);
    check("wrap_freq_before", freq_out, 0);
    check("wrap_score_before", score_out, 0);
    apply_tick();
    check("wrap_x", x_out, 1280);
    check("wrap_score", score_out, 1);
    check("wrap_freq", freq_out, 16'h0ABC);
    check("wrap_no_coll", seen_coll, 0);

    player_y_in = 10'd250;
    for (int i = 0; i < 267; i++) apply_tick();
    check("pre_hit_x", x_out, 212);
    check("pre_hit_state", state_out, 1);
    hcount_in = 11'd0;
    cycle();
    check("hit_state", state_out, 2);
    check("hit_coll", collision_out, 1);
    hcount_in = 11'd1;
    cycle();
    check("hit_coll_pulse", collision_out, 0);
    check("hit_x", x_out, 212);
    apply_tick();
    check("hit_hold_x", x_out, 212);
    check("hit_hold_state", state_out, 2);
    pulse_start();
    check("hit_restart_state", state_out, 0);
    check("hit_restart_x", x_out, 1280);
    check("hit_restart_score", score_out, 1);
    pulse_start();
    check("rerun_state", state_out, 1);
    check("rerun_score", score_out, 0);

    // Frame counters parked on the tick position for several cycles.
    hcount_in = 11'd0; vcount_in = 10'd720;
    for (int i = 0; i < 5; i++) cycle();
    check("hold_match_x", x_out, 1276);
    hcount_in = 11'd1;
    cycle();

    // Asynchronous reset in the middle of a run.
    do_reset();
    player_y_in = 10'd0; gap_height_in = 9'd208;
    pulse_start();
    for (int i = 0; i < 3 * 321 + 170; i++) apply_tick();
    check("mid_x", x_out, 600);
    check("mid_score", score_out, 3);
    freq_valid_in = 1; freq_in = 16'h5555;
    cycle();
    freq_valid_in = 0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_state", state_out, 0);
    check("async_x", x_out, 1280);
    check("async_freq", freq_out, 0);
    check("async_score", score_out, 0);
    check("async_coll", collision_out, 0);
    cycle();
    rst = 1'b1;
    pulse_start();
    check("async_pending_cleared", freq_out, 0);

    // Score ceiling on the fast instance.
    do_reset();
    pulse_start();
    apply_tick();
    check("fast_x_zero", x_s, 0);
    for (int i = 1; i < 508; i++) apply_tick();
    check("sat_score_254", score_s, 254);
    apply_tick(); apply_tick();
    check("sat_score_255", score_s, 255);
    check("sat_x", x_s, 1280);
    apply_tick(); apply_tick();
    check("sat_score_hold", score_s, 255);
    check("sat_state", state_s, 1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      start_in = ($urandom_range(0, 15) == 0);
      freq_valid_in = ($urandom_range(0, 3) == 0);
      freq_in = 16'($urandom);
      hcount_in = ($urandom_range(0, 2) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
      vcount_in = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'd720;
      if ($urandom_range(0, 31) == 0) begin
        player_y_in = 10'($urandom);
        gap_height_in = 9'($urandom_range(208, 511));
      end
      cycle();
      check("rand_state", state_out, m_state);
      check("rand_x", x_out, m_x);
      check("rand_freq", freq_out, m_freq);
      check("rand_score", score_out, m_score);
      check("rand_coll", collision_out, m_coll);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
